mem_dma_ctrl: RTL and testbench

Initiator-side controller for the single-port word memory used by the multicycle processor. On a start pulse it runs a block copy or block fill, driving the memory's address, write data, read flag and write flag, and consuming its registered read data. It sits between the control unit (or a testbench) and the memory, and frees the datapath from sequencing multi-word transfers.

---
 rtl/mem_dma_pkg.sv | 11 +
 rtl/mem_dma_ctrl_if.sv | 19 +
 rtl/mem_dma_ctrl.sv | 84 ++++++++
 tb/tb_mem_dma_ctrl.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/mem_dma_pkg.sv
// mem_dma_pkg: shared state encoding, mode constants and default widths
// for the block copy/fill memory controller.
package mem_dma_pkg;
    typedef enum logic [2:0] {IDLE, RD, CAP, WR, DONE} state_t;
    localparam logic MODE_COPY = 1'b0;
    localparam logic MODE_FILL = 1'b1;
    localparam int DMA_DATA_W = 32;
    localparam int DMA_ADDR_W = 32;
    localparam int DMA_MEM_DEPTH = 32;
    localparam int DMA_LEN_W = 6;
endpackage

// File: rtl/mem_dma_ctrl_if.sv
// mem_dma_ctrl_if: request/status and memory-bus signals of the DMA controller.
interface mem_dma_ctrl_if import mem_dma_pkg::*; #(
    parameter int DATA_W = DMA_DATA_W,
    parameter int ADDR_W = DMA_ADDR_W,
    parameter int LEN_W = DMA_LEN_W
);
    logic start, mode, abort, busy, done, mem_flag_read, mem_flag_write;
    logic [ADDR_W-1:0] src_addr, dst_addr, mem_address;
    logic [LEN_W-1:0] length, words_done;
    logic [DATA_W-1:0] fill_value, mem_data_in, mem_data_out;
    modport master (
        input start, mode, src_addr, dst_addr, length, fill_value, abort, mem_data_out,
        output busy, done, words_done, mem_address, mem_data_in, mem_flag_read, mem_flag_write
    );
    modport slave (
        output start, mode, src_addr, dst_addr, length, fill_value, abort, mem_data_out,
        input busy, done, words_done, mem_address, mem_data_in, mem_flag_read, mem_flag_write
    );
endinterface

// File: rtl/mem_dma_ctrl.sv
// mem_dma_ctrl: sequences block copy (read, capture, write per word) or block fill
// (one write per word) against a single-port memory with one-cycle read latency.
module mem_dma_ctrl import mem_dma_pkg::*; #(
    parameter int DATA_W = DMA_DATA_W,
    parameter int ADDR_W = DMA_ADDR_W,
    parameter int MEM_DEPTH = DMA_MEM_DEPTH,
    parameter int LEN_W = DMA_LEN_W
) (
    input logic clk,
    input logic reset,
    mem_dma_ctrl_if.master bus
);
    // Pointers are kept pre-masked so the upper address bits are always zero.
    localparam logic [ADDR_W-1:0] MASK = ADDR_W'(MEM_DEPTH - 1);
    state_t state_q, state_d;
    logic [ADDR_W-1:0] src_q, src_d, dst_q, dst_d;
    logic [LEN_W-1:0] len_q, len_d, cnt_q, cnt_d;
    logic mode_q, mode_d;
    logic [DATA_W-1:0] fill_q, fill_d, buf_q, buf_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            src_q <= '0;
            dst_q <= '0;
            len_q <= '0;
            cnt_q <= '0;
            mode_q <= MODE_COPY;
            fill_q <= '0;
            buf_q <= '0;
        end else begin
            state_q <= state_d;
            src_q <= src_d;
            dst_q <= dst_d;
            len_q <= len_d;
            cnt_q <= cnt_d;
            mode_q <= mode_d;
            fill_q <= fill_d;
            buf_q <= buf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        src_d = src_q;
        dst_d = dst_q;
        len_d = len_q;
        cnt_d = cnt_q;
        mode_d = mode_q;
        fill_d = fill_q;
        buf_d = buf_q;
        case (state_q)
            IDLE: if (bus.start) begin
                src_d = bus.src_addr & MASK;
                dst_d = bus.dst_addr & MASK;
                len_d = bus.length;
                mode_d = bus.mode;
                fill_d = bus.fill_value;
                cnt_d = '0;
                state_d = bus.length == '0 ? DONE : bus.mode == MODE_FILL ? WR : RD;
            end
            RD: state_d = bus.abort ? DONE : CAP;
            CAP: begin
                buf_d = bus.mem_data_out;
                state_d = bus.abort ? DONE : WR;
            end
            WR: begin
                src_d = (src_q + 1'b1) & MASK;
                dst_d = (dst_q + 1'b1) & MASK;
                cnt_d = cnt_q + 1'b1;
                state_d = (bus.abort || cnt_d == len_q) ? DONE : mode_q == MODE_FILL ? WR : RD;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.busy = state_q != IDLE;
    assign bus.done = state_q == DONE;
    assign bus.words_done = cnt_q;
    assign bus.mem_flag_read = state_q == RD;
    assign bus.mem_flag_write = state_q == WR;
    assign bus.mem_address = state_q == RD ? src_q : state_q == WR ? dst_q : '0;
    assign bus.mem_data_in = state_q == WR ? (mode_q == MODE_FILL ? fill_q : buf_q) : '0;
endmodule

// File: tb/tb_mem_dma_ctrl.sv
// tb_mem_dma_ctrl: random and directed copy/fill transfers against a word-level
// reference memory; a monitor checks every memory access and completion.
module tb_mem_dma_ctrl;
    import mem_dma_pkg::*;
    localparam int DW = 32, AW = 32, DEPTH = 32, LW = 6;
    typedef struct {int cyc; logic [AW-1:0] addr; logic [DW-1:0] data;} wr_t;
    typedef struct {int cyc; logic [AW-1:0] addr;} rd_t;
    typedef struct {int cyc; logic [LW-1:0] words;} dn_t;

    logic clk = 0, reset = 1, after_done = 0;
    logic poke_en = 0;
    logic [4:0] poke_a = 0;
    logic [DW-1:0] poke_d = 0, rdata = 0;
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] ref_mem [DEPTH];
    int cyc = 0, base = 0, n_chk = 0, n_fail = 0;
    wr_t wq[$];
    rd_t rq[$];
    dn_t dq[$];

    mem_dma_ctrl_if #(.DATA_W(DW), .ADDR_W(AW), .LEN_W(LW)) bus();
    mem_dma_ctrl #(.DATA_W(DW), .ADDR_W(AW), .MEM_DEPTH(DEPTH), .LEN_W(LW)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Responder memory: registered read data, one-cycle latency.
    always @(posedge clk) begin
        if (poke_en) mem[poke_a] <= poke_d;
        else if (bus.mem_flag_write) mem[bus.mem_address[4:0]] <= bus.mem_data_in;
        if (bus.mem_flag_read) rdata <= mem[bus.mem_address[4:0]];
    end
    assign bus.mem_data_out = rdata;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (time %0t)", name, act, exp, $time);
        end
    endfunction

    function automatic int nat_cycles(logic m, int len);
        return len == 0 ? 1 : m == MODE_FILL ? len + 1 : 3 * len + 1;
    endfunction

    always @(negedge clk) begin : monitor
        int cur;
        wr_t w;
        rd_t r;
        dn_t d;
        cur = cyc - base + 1;
        if (reset) after_done = 0;
        else begin
            if (after_done) chk("busy_after_done", 64'(bus.busy), 64'd0);
            if (bus.mem_flag_read || bus.mem_flag_write)
                chk("flags_exclusive", 64'(bus.mem_flag_read & bus.mem_flag_write), 64'd0);
            if (bus.mem_flag_read) begin
                if (rq.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL unexpected_read: addr %0h at cycle %0d", bus.mem_address, cur);
                end else begin
                    r = rq.pop_front();
                    chk("read_cycle", 64'(cur), 64'(r.cyc));
                    chk("read_addr", 64'(bus.mem_address), 64'(r.addr));
                end
            end
            if (bus.mem_flag_write) begin
                if (wq.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL unexpected_write: addr %0h data %0h at cycle %0d", bus.mem_address, bus.mem_data_in, cur);
                end else begin
                    w = wq.pop_front();
                    chk("write_cycle", 64'(cur), 64'(w.cyc));
                    chk("write_addr", 64'(bus.mem_address), 64'(w.addr));
                    chk("write_data", 64'(bus.mem_data_in), 64'(w.data));
                end
            end
            if (bus.done) begin
                if (dq.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL unexpected_done: at cycle %0d", cur);
                end else begin
                    d = dq.pop_front();
                    chk("done_cycle", 64'(cur), 64'(d.cyc));
                    chk("words_done", 64'(bus.words_done), 64'(d.words));
                    chk("busy_in_done", 64'(bus.busy), 64'd1);
                end
            end
            after_done = bus.done;
        end
    end

    task automatic poke(input int a, input logic [DW-1:0] v);
        @(negedge clk);
        poke_en = 1; poke_a = 5'(a); poke_d = v; ref_mem[a] = v;
        @(negedge clk);
        poke_en = 0;
    endtask

    // Model: word i is read at 3i+1 and written at 3i+3 (copy) or written at i+1 (fill);
    // abort in cycle a ends with done at a+1; cut_cyc models a reset landing in that cycle.
    task automatic run(input logic m, input logic [AW-1:0] src, input logic [AW-1:0] dst,
                       input int len, input logic [DW-1:0] val, input int abort_cyc,
                       input int restart_cyc, input int cut_cyc);
        int nat, dn, words, stop;
        nat = nat_cycles(m, len);
        dn = (abort_cyc >= 1 && abort_cyc < nat) ? abort_cyc + 1 : nat;
        stop = cut_cyc > 0 ? cut_cyc : dn;
        words = 0;
        for (int i = 0; i < len; i++) begin
            logic [4:0] s, d;
            logic [DW-1:0] v;
            s = src[4:0] + 5'(i);
            d = dst[4:0] + 5'(i);
            if (m == MODE_COPY && 3 * i + 1 < stop) rq.push_back('{3 * i + 1, AW'(s)});
            if ((m == MODE_FILL ? i + 1 : 3 * i + 3) < stop) begin
                v = m == MODE_FILL ? val : ref_mem[s];
                ref_mem[d] = v;
                wq.push_back('{m == MODE_FILL ? i + 1 : 3 * i + 3, AW'(d), v});
                words++;
            end
        end
        if (cut_cyc == 0) dq.push_back('{dn, LW'(words)});
        @(negedge clk);
        bus.mode = m; bus.src_addr = src; bus.dst_addr = dst;
        bus.length = LW'(len); bus.fill_value = val; bus.start = 1;
        base = cyc + 1;
        for (int k = 1; k <= (cut_cyc > 0 ? cut_cyc - 1 : dn + 1); k++) begin
            @(negedge clk);
            bus.start = k == restart_cyc;
            bus.abort = k == abort_cyc;
            if (k == restart_cyc) begin
                bus.mode = 1'($urandom); bus.src_addr = $urandom; bus.dst_addr = $urandom;
                bus.length = LW'($urandom_range(1, 32)); bus.fill_value = $urandom;
            end
        end
        if (cut_cyc == 0) chk("queues_drained", 64'(wq.size() + rq.size() + dq.size()), 64'd0);
    endtask

    initial begin
        bus.start = 0; bus.abort = 0; bus.mode = 0; bus.src_addr = 0; bus.dst_addr = 0;
        bus.length = 0; bus.fill_value = 0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_rd", 64'(bus.mem_flag_read), 64'd0);
        chk("rst_wr", 64'(bus.mem_flag_write), 64'd0);
        chk("rst_words", 64'(bus.words_done), 64'd0);
        chk("rst_addr", 64'(bus.mem_address), 64'd0);
        chk("rst_din", 64'(bus.mem_data_in), 64'd0);
        reset = 0;
        for (int i = 0; i < DEPTH; i++) poke(i, $urandom);
        poke(0, 11); poke(1, 22); poke(2, 33); poke(3, 44);
        run(MODE_COPY, 0, 8, 4, 0, 0, 0, 0);
        run(MODE_FILL, 0, 30, 4, 32'hDEADBEEF, 0, 0, 0);
        run(MODE_COPY, 5, 9, 0, 0, 0, 0, 0);
        run(MODE_COPY, 0, 12, 8, 0, 8, 0, 0);
        poke(0, 7);
        run(MODE_COPY, 0, 1, 3, 0, 0, 2, 0);
        // Reset lands mid-cycle during the WR of the second copied word.
        run(MODE_COPY, 4, 20, 4, 0, 0, 0, 6);
        @(posedge clk);
        #2 reset = 1;
        #1;
        chk("arst_busy", 64'(bus.busy), 64'd0);
        chk("arst_wr", 64'(bus.mem_flag_write), 64'd0);
        chk("arst_rd", 64'(bus.mem_flag_read), 64'd0);
        chk("arst_words", 64'(bus.words_done), 64'd0);
        chk("arst_addr", 64'(bus.mem_address), 64'd0);
        @(negedge clk);
        reset = 0;
        chk("arst_queues", 64'(wq.size() + rq.size() + dq.size()), 64'd0);
        run(MODE_FILL, 0, 5, 3, 32'h0BADF00D, 0, 0, 0);
        for (int t = 0; t < 10; t++) begin
            logic m;
            int len, nat, ab;
            m = 1'($urandom);
            len = $urandom_range(0, 32);
            nat = nat_cycles(m, len);
            ab = (len > 0 && $urandom_range(0, 2) == 0) ? $urandom_range(1, nat - 1) : 0;
            run(m, $urandom, $urandom, len, $urandom, ab, nat > 3 ? 2 : 0, 0);
        end
        @(negedge clk);
        for (int i = 0; i < DEPTH; i++) chk($sformatf("mem_final[%0d]", i), 64'(mem[i]), 64'(ref_mem[i]));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
